write_buffer: RTL

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer_if.sv | 30 +++
 rtl/write_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/write_buffer_if.sv
// Bus bundle for the write buffer: CPU port, cache read handshake and SDRAM write port.
// The slave modport is the buffer itself; master is the CPU/cache/SDRAM environment.
interface write_buffer_if;
   logic [31:0] cpu_addr;
   logic        cpu_req;
   logic        cpu_rw;
   logic [3:0]  cpu_bytesel;
   logic [31:0] data_from_cpu;
   logic        cpu_ack;
   logic        cache_req;
   logic        cache_ack;
   logic        sdram_wr_req;
   logic [29:0] sdram_wr_addr;
   logic [31:0] sdram_wr_data;
   logic [3:0]  sdram_wr_bytesel;
   logic        sdram_wr_ack;
   logic        wb_empty;

   modport slave (
      input  cpu_addr, cpu_req, cpu_rw, cpu_bytesel, data_from_cpu, cache_ack, sdram_wr_ack,
      output cpu_ack, cache_req, sdram_wr_req, sdram_wr_addr, sdram_wr_data, sdram_wr_bytesel,
             wb_empty
   );

   modport master (
      output cpu_addr, cpu_req, cpu_rw, cpu_bytesel, data_from_cpu, cache_ack, sdram_wr_ack,
      input  cpu_ack, cache_req, sdram_wr_req, sdram_wr_addr, sdram_wr_data, sdram_wr_bytesel,
             wb_empty
   );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer between a CPU and an SDRAM controller: writes are queued and drained
// in order, byte-merged into the newest entry, and reads wait until every write has drained.
module write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   write_buffer_if.slave  bus
);

   localparam int            PW     = $clog2(DEPTH);
   localparam logic [PW:0]   L_FULL = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   L_ONE  = (PW + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WACK,
      S_RDWAIT,
      S_RDPASS,
      S_RDEND
   } state_t;

   state_t        r_state;
   logic [29:0]   r_mem_addr [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];
   logic [3:0]    r_mem_bsel [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW:0]   r_count;
   logic          r_wack;
   logic          r_cache_req;
   logic          r_wr_req;
   logic [29:0]   r_wr_addr;
   logic [31:0]   r_wr_data;
   logic [3:0]    r_wr_bsel;

   logic [PW-1:0] w_newest;
   logic          w_push;
   logic          w_merge;
   logic          w_alloc;
   logic          w_pop;
   logic          w_empty;

   // With two or more entries the newest one can never be the head on the SDRAM port.
   assign w_newest = r_tail - 1'b1;
   assign w_push   = (r_state == S_IDLE) && bus.cpu_req && !bus.cpu_rw && (r_count != L_FULL);
   assign w_merge  = w_push && (r_count > L_ONE) && (r_mem_addr[w_newest] == bus.cpu_addr[31:2]);
   assign w_alloc  = w_push && !w_merge;
   assign w_pop    = r_wr_req && bus.sdram_wr_ack;
   assign w_empty  = (r_count == '0) && !r_wr_req;

   // NOTE: the entry storage has no reset; count and pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (w_merge) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.cpu_bytesel[b]) begin
               r_mem_data[w_newest][8*b +: 8] <= bus.data_from_cpu[8*b +: 8];
            end
         end
         r_mem_bsel[w_newest] <= r_mem_bsel[w_newest] | bus.cpu_bytesel;
      end else if (w_alloc) begin
         r_mem_addr[r_tail] <= bus.cpu_addr[31:2];
         r_mem_data[r_tail] <= bus.data_from_cpu;
         r_mem_bsel[r_tail] <= bus.cpu_bytesel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_wr_req  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_bsel <= '0;
      end else begin
         if (w_alloc) r_tail <= r_tail + 1'b1;
         if (w_pop)   r_head <= r_head + 1'b1;
         case ({w_alloc, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // Acks arriving with no request outstanding fall through untouched.
         if (!r_wr_req) begin
            if (r_count != '0) begin
               r_wr_req  <= 1'b1;
               r_wr_addr <= r_mem_addr[r_head];
               r_wr_data <= r_mem_data[r_head];
               r_wr_bsel <= r_mem_bsel[r_head];
            end
         end else if (bus.sdram_wr_ack) begin
            r_wr_req <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wack      <= 1'b0;
         r_cache_req <= 1'b0;
      end else begin
         r_wack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cpu_req && bus.cpu_rw) begin
                  r_state <= S_RDWAIT;
               end else if (w_push) begin
                  r_wack  <= 1'b1;
                  r_state <= S_WACK;
               end
            end
            S_WACK: begin
               if (!bus.cpu_req) r_state <= S_IDLE;
            end
            S_RDWAIT: begin
               if (w_empty) begin
                  r_cache_req <= 1'b1;
                  r_state     <= S_RDPASS;
               end
            end
            S_RDPASS: begin
               if (bus.cache_ack) begin
                  r_cache_req <= 1'b0;
                  r_state     <= S_RDEND;
               end
            end
            S_RDEND: begin
               if (!bus.cpu_req) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_ack          = r_wack ||
                                 (((r_state == S_RDPASS) || (r_state == S_RDEND)) && bus.cache_ack);
   assign bus.cache_req        = r_cache_req;
   assign bus.sdram_wr_req     = r_wr_req;
   assign bus.sdram_wr_addr    = r_wr_addr;
   assign bus.sdram_wr_data    = r_wr_data;
   assign bus.sdram_wr_bytesel = r_wr_bsel;
   assign bus.wb_empty         = w_empty;

endmodule
